// File: rtl/petris_pkg.sv
// Shared types and constants for the double-buffered playfield store.
package petris_pkg;

  localparam int unsigned DefCols = 10;
  localparam int unsigned DefRows = 20;
  localparam int unsigned PixW    = 3;

  typedef logic [PixW-1:0] cell_t;

  localparam cell_t ColBlank  = 3'd0;
  localparam cell_t ColRed    = 3'd1;
  localparam cell_t ColGreen  = 3'd2;
  localparam cell_t ColYellow = 3'd3;
  localparam cell_t ColBlue   = 3'd4;
  localparam cell_t ColPurple = 3'd5;
  localparam cell_t ColCyan   = 3'd6;
  localparam cell_t ColWhite  = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StCopy,
    StClear
  } state_e;

endpackage

// File: rtl/petris_bank_ram.sv
// One playfield bank: a write port, a registered display read port and an
// unregistered tap used by the copy engine to stream this bank into the other.
module petris_bank_ram #(
  parameter int unsigned DEPTH = 200,
  parameter int unsigned WIDTH = 3,
  parameter int unsigned AW    = 8
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic [AW-1:0]    caddr,
  output logic [WIDTH-1:0] cdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

  assign cdata = mem[caddr];

endmodule

// File: rtl/petris_frame_store.sv
// Double-buffered playfield store: game logic writes the back bank, VGA reads
// the front bank; banks swap on vsync and the back bank is then refreshed.
module petris_frame_store
  import petris_pkg::*;
#(
  parameter int unsigned COLS   = DefCols,
  parameter int unsigned ROWS   = DefRows,
  parameter int unsigned PIX_W  = PixW,
  parameter int unsigned FCNT_W = 11,
  parameter int unsigned COL_W  = $clog2(COLS),
  parameter int unsigned ROW_W  = $clog2(ROWS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vsync,
  input  logic              swap_en,
  input  logic              wr_en,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [PIX_W-1:0]  wr_pix,
  output logic              wr_ready,
  input  logic              clear_req,
  input  logic [COL_W-1:0]  rd_col,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [PIX_W-1:0]  rd_pix,
  output logic              front_bank,
  output logic              busy,
  output logic              swap_pending,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int unsigned Cells = COLS * ROWS;
  localparam int unsigned IdxW  = $clog2(Cells);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Cells - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              front_q, front_d;
  logic              pend_swap_q, pend_swap_d;
  logic              pend_clr_q, pend_clr_d;
  logic              vs_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              rd_ok_q, rd_sel_q;

  logic              vs_edge, swap_req;
  logic              wr_ok, rd_ok;
  logic [IdxW-1:0]   wr_idx, rd_idx, rd_addr;
  logic              bk_we;
  logic [IdxW-1:0]   bk_addr;
  logic [PIX_W-1:0]  bk_data;
  logic [PIX_W-1:0]  rdata0, rdata1, cdata0, cdata1, front_cdata;

  assign vs_edge  = vsync & ~vs_q;
  assign swap_req = vs_edge & swap_en;

  assign wr_ok  = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
  assign rd_ok  = (32'(rd_col) < COLS) && (32'(rd_row) < ROWS);
  assign wr_idx = IdxW'(wr_row) * IdxW'(COLS) + IdxW'(wr_col);
  assign rd_idx = IdxW'(rd_row) * IdxW'(COLS) + IdxW'(rd_col);
  // Keep the RAM address inside the array; the output is masked anyway.
  assign rd_addr = rd_ok ? rd_idx : '0;

  assign front_cdata = front_q ? cdata1 : cdata0;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    front_d     = front_q;
    pend_swap_d = pend_swap_q;
    pend_clr_d  = pend_clr_q;
    bk_we       = 1'b0;
    bk_addr     = idx_q;
    bk_data     = '0;
    unique case (state_q)
      StIdle: begin
        bk_we   = wr_en & wr_ok;
        bk_addr = wr_idx;
        bk_data = wr_pix;
        if (swap_req || pend_swap_q) begin
          front_d     = ~front_q;
          state_d     = StCopy;
          idx_d       = '0;
          pend_swap_d = 1'b0;
          if (clear_req) pend_clr_d = 1'b1;
        end else if (clear_req || pend_clr_q) begin
          state_d    = StClear;
          idx_d      = '0;
          pend_clr_d = 1'b0;
        end
      end
      StCopy, StClear: begin
        bk_we   = 1'b1;
        bk_data = (state_q == StCopy) ? front_cdata : '0;
        if (swap_req) pend_swap_d = 1'b1;
        if (clear_req && state_q == StCopy) pend_clr_d = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      front_q     <= 1'b0;
      pend_swap_q <= 1'b0;
      pend_clr_q  <= 1'b0;
      vs_q        <= 1'b0;
      fcnt_q      <= '0;
      rd_ok_q     <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      front_q     <= front_d;
      pend_swap_q <= pend_swap_d;
      pend_clr_q  <= pend_clr_d;
      vs_q        <= vsync;
      if (vs_edge) fcnt_q <= fcnt_q + 1'b1;
      rd_ok_q     <= rd_ok;
      rd_sel_q    <= front_q;
    end
  end

  // The back bank is always the one not displayed.
  petris_bank_ram #(
    .DEPTH (Cells),
    .WIDTH (PIX_W),
    .AW    (IdxW)
  ) u_bank0 (
    .clock (clock),
    .we    (bk_we & front_q),
    .waddr (bk_addr),
    .wdata (bk_data),
    .raddr (rd_addr),
    .rdata (rdata0),
    .caddr (idx_q),
    .cdata (cdata0)
  );

  petris_bank_ram #(
    .DEPTH (Cells),
    .WIDTH (PIX_W),
    .AW    (IdxW)
  ) u_bank1 (
    .clock (clock),
    .we    (bk_we & ~front_q),
    .waddr (bk_addr),
    .wdata (bk_data),
    .raddr (rd_addr),
    .rdata (rdata1),
    .caddr (idx_q),
    .cdata (cdata1)
  );

  assign rd_pix       = !rd_ok_q ? '0 : (rd_sel_q ? rdata1 : rdata0);
  assign front_bank   = front_q;
  assign busy         = (state_q != StIdle);
  assign wr_ready     = (state_q == StIdle);
  assign swap_pending = pend_swap_q;
  assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_petris_frame_store.sv
// Directed bench for petris_frame_store: write/read tables plus hand-built
// sequences for swap deferral, clear latching, reset abort and frame wrap.
module tb_petris_frame_store;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic        swap_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_col = '0;
  logic [4:0]  wr_row = '0;
  logic [2:0]  wr_pix = '0;
  logic        wr_ready;
  logic        clear_req = 1'b0;
  logic [3:0]  rd_col = '0;
  logic [4:0]  rd_row = '0;
  logic [2:0]  rd_pix;
  logic        front_bank;
  logic        busy;
  logic        swap_pending;
  logic [10:0] frame_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_fc = 0;

  typedef struct {
    int col;
    int row;
    int pix;
  } vec_t;

  vec_t wv[7];
  vec_t rv[10];

  petris_frame_store dut (
    .clock        (clock),
    .reset        (reset),
    .vsync        (vsync),
    .swap_en      (swap_en),
    .wr_en        (wr_en),
    .wr_col       (wr_col),
    .wr_row       (wr_row),
    .wr_pix       (wr_pix),
    .wr_ready     (wr_ready),
    .clear_req    (clear_req),
    .rd_col       (rd_col),
    .rd_row       (rd_row),
    .rd_pix       (rd_pix),
    .front_bank   (front_bank),
    .busy         (busy),
    .swap_pending (swap_pending),
    .frame_count  (frame_count)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      tick();
    end
  endtask

  task automatic pulse_vsync(input logic sw);
    vsync   = 1'b1;
    swap_en = sw;
    tick();
    vsync   = 1'b0;
    swap_en = 1'b0;
    tick();
    exp_fc++;
  endtask

  task automatic read_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      rd_col = 4'(rv[i].col);
      rd_row = 5'(rv[i].row);
      tick();
      chk($sformatf("%s rd(%0d,%0d)", tag, rv[i].col, rv[i].row), 32'(rd_pix), rv[i].pix);
    end
  endtask

  initial begin
    int cnt;
    logic bad;

    wv[0] = '{3, 5, 5};  wv[1] = '{0, 0, 1};  wv[2] = '{9, 19, 7};
    wv[3] = '{9, 0, 2};  wv[4] = '{0, 19, 3}; wv[5] = '{10, 0, 6};
    wv[6] = '{0, 20, 4};
    rv[0] = '{3, 5, 5};  rv[1] = '{0, 0, 1};  rv[2] = '{9, 19, 7};
    rv[3] = '{9, 0, 2};  rv[4] = '{0, 19, 3}; rv[5] = '{0, 1, 0};
    rv[6] = '{10, 0, 0}; rv[7] = '{0, 20, 0}; rv[8] = '{15, 31, 0};
    rv[9] = '{4, 4, 4};

    // Reset values
    tick();
    tick();
    chk("rst front_bank", 32'(front_bank), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst swap_pending", 32'(swap_pending), 0);
    chk("rst frame_count", 32'(frame_count), 0);
    chk("rst rd_pix", 32'(rd_pix), 0);
    chk("rst wr_ready", 32'(wr_ready), 1);
    reset = 1'b0;
    tick();

    // Clear the back bank: busy for exactly 200 cycles
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clear busy", 32'(busy), 1);
    chk("clear wr_ready", 32'(wr_ready), 0);
    wait_idle(cnt);
    chk("clear length", cnt, 200);

    // Swap in the cleared bank; copy refreshes the other one
    pulse_vsync(1'b1);
    chk("swap1 front_bank", 32'(front_bank), 1);
    wait_idle(cnt);
    chk("swap1 copy length", cnt, 199);

    // Writes into back bank (0), including out-of-range ones
    for (int i = 0; i < 7; i++) begin
      wr_en  = 1'b1;
      wr_col = 4'(wv[i].col);
      wr_row = 5'(wv[i].row);
      wr_pix = 3'(wv[i].pix);
      chk($sformatf("wr_ready w%0d", i), 32'(wr_ready), 1);
      tick();
    end
    // Write coinciding with swap lands in the new front
    wr_col  = 4'd4;
    wr_row  = 5'd4;
    wr_pix  = 3'd4;
    vsync   = 1'b1;
    swap_en = 1'b1;
    tick();
    wr_en   = 1'b0;
    vsync   = 1'b0;
    swap_en = 1'b0;
    exp_fc++;
    chk("swap2 front_bank", 32'(front_bank), 0);
    chk("swap2 busy", 32'(busy), 1);
    chk("swap2 frame_count", 32'(frame_count), exp_fc);
    read_table("front0");
    wait_idle(cnt);

    // Swap to the copied bank; contents must match
    pulse_vsync(1'b1);
    chk("swap3 front_bank", 32'(front_bank), 1);
    read_table("front1");

    // Edges during COPY defer the swap and collapse; clear is latched
    pulse_vsync(1'b1);
    chk("defer swap_pending", 32'(swap_pending), 1);
    chk("defer front_bank", 32'(front_bank), 1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    pulse_vsync(1'b1);
    chk("defer2 front_bank", 32'(front_bank), 1);
    wait_idle(cnt);
    chk("after copy busy", 32'(busy), 0);
    chk("after copy pending", 32'(swap_pending), 1);
    chk("after copy front_bank", 32'(front_bank), 1);
    tick();
    chk("late swap front_bank", 32'(front_bank), 0);
    chk("late swap busy", 32'(busy), 1);
    chk("late swap pending", 32'(swap_pending), 0);
    wait_idle(cnt);
    chk("late copy length", cnt, 200);
    tick();
    chk("latched clear busy", 32'(busy), 1);
    wait_idle(cnt);
    chk("latched clear length", cnt, 200);
    chk("collapse front_bank", 32'(front_bank), 0);
    chk("frame_count mid", 32'(frame_count), exp_fc);
    rd_col = 4'd3;
    rd_row = 5'd5;
    tick();
    chk("front0 keeps data", 32'(rd_pix), 5);
    pulse_vsync(1'b1);
    chk("cleared bank (3,5)", 32'(rd_pix), 0);
    rd_col = 4'd4;
    rd_row = 5'd4;
    tick();
    chk("cleared bank (4,4)", 32'(rd_pix), 0);
    wait_idle(cnt);

    // Reset 50 cycles into CLEAR
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (49) tick();
    chk("pre-reset busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    chk("abort busy", 32'(busy), 0);
    chk("abort wr_ready", 32'(wr_ready), 1);
    chk("abort front_bank", 32'(front_bank), 0);
    chk("abort frame_count", 32'(frame_count), 0);
    chk("abort rd_pix", 32'(rd_pix), 0);
    reset = 1'b0;
    tick();
    chk("abort stays idle", 32'(busy), 0);
    wr_en  = 1'b1;
    wr_col = 4'd1;
    wr_row = 5'd1;
    wr_pix = 3'd3;
    chk("post-reset wr_ready", 32'(wr_ready), 1);
    tick();
    wr_en = 1'b0;
    chk("post-reset write idle", 32'(busy), 0);

    // Frame counter wrap with swaps disabled
    bad = 1'b0;
    for (int i = 0; i < 2047; i++) begin
      pulse_vsync(1'b0);
      if (busy || front_bank) bad = 1'b1;
    end
    chk("frame_count 2047", 32'(frame_count), 2047);
    pulse_vsync(1'b0);
    chk("frame_count wrap", 32'(frame_count), 0);
    chk("wrap front_bank", 32'(front_bank), 0);
    chk("wrap busy never", 32'(bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
